// File: rtl/prio_arbiter_rr.sv
// N-way request arbiter with a registered grant, fixed-priority or round-robin
// selection, and a valid/ready handshake toward the consumer of the grant.
module prio_arbiter_rr #(
  parameter int N    = 4,
  parameter int IDXW = 2,
  parameter int MODE = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [N-1:0]    req,
  input  logic            ready,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx,
  output logic [N-1:0]    gnt_onehot
);

  logic            r_valid;
  logic [IDXW-1:0] r_idx;
  logic [N-1:0]    r_onehot;
  logic [IDXW-1:0] r_ptr;

  logic            w_handshake;
  logic            w_load;
  logic            w_anyReq;
  logic [IDXW-1:0] w_ptrEff;
  logic [N-1:0]    w_lowMask;
  logic [N-1:0]    w_reqLow;
  logic [IDXW-1:0] w_winnerFixed;
  logic [IDXW-1:0] w_winnerLow;
  logic [IDXW-1:0] w_winnerRr;
  logic [IDXW-1:0] w_winner;
  logic [N-1:0]    w_winnerOnehot;

  function automatic logic [IDXW-1:0] highestSet(input logic [N-1:0] v);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = IDXW'(i);
    end
    return idx;
  endfunction

  assign w_handshake = r_valid & ready;
  assign w_load      = en & (~r_valid | ready);
  assign w_anyReq    = |req;

  // A grant consumed on this edge already moves the pointer for the grant loaded on the same edge.
  assign w_ptrEff = w_handshake ? r_idx : r_ptr;

  always_comb begin
    w_lowMask = '0;
    for (int i = 0; i < N; i++) begin
      w_lowMask[i] = (IDXW'(i) < w_ptrEff);
    end
  end

  assign w_reqLow      = req & w_lowMask;
  assign w_winnerFixed = highestSet(req);
  assign w_winnerLow   = highestSet(w_reqLow);

  // Indices below the pointer are scanned first; otherwise the highest request (down to ptr) wins.
  assign w_winnerRr     = (|w_reqLow) ? w_winnerLow : w_winnerFixed;
  assign w_winner       = (MODE == 1) ? w_winnerRr : w_winnerFixed;
  assign w_winnerOnehot = {{(N-1){1'b0}}, 1'b1} << w_winner;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_ptr    <= '0;
    end else begin
      if (w_handshake) r_ptr <= r_idx;
      if (w_load) begin
        if (w_anyReq) begin
          r_valid  <= 1'b1;
          r_idx    <= w_winner;
          r_onehot <= w_winnerOnehot;
        end else begin
          r_valid  <= 1'b0;
          r_onehot <= '0;
        end
      end else if (w_handshake) begin
        r_valid  <= 1'b0;
        r_onehot <= '0;
      end
    end
  end

  assign gnt_valid  = r_valid;
  assign gnt_idx    = r_idx;
  assign gnt_onehot = r_onehot;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Bench for prio_arbiter_rr: three instances (fixed N=4, round-robin N=4 and N=5)
// driven by shared stimulus and checked against a scan-order reference model.
module tb_prio_arbiter_rr;

  logic       clk;
  logic       reset;
  logic       en;
  logic       ready;
  logic [4:0] req5;

  logic       v0, v1, v2;
  logic [1:0] i0, i1;
  logic [2:0] i2;
  logic [3:0] o0, o1;
  logic [4:0] o2;

  int vectors;
  int miscompares;
  bit checkEn;

  typedef struct packed {
    logic       v;
    logic [2:0] idx;
    logic [2:0] ptr;
  } mstate_t;

  mstate_t mS [3];

  prio_arbiter_rr #(.N(4), .IDXW(2), .MODE(0)) u_fixed (
    .clk(clk), .reset(reset), .en(en), .req(req5[3:0]), .ready(ready),
    .gnt_valid(v0), .gnt_idx(i0), .gnt_onehot(o0));

  prio_arbiter_rr #(.N(4), .IDXW(2), .MODE(1)) u_rr4 (
    .clk(clk), .reset(reset), .en(en), .req(req5[3:0]), .ready(ready),
    .gnt_valid(v1), .gnt_idx(i1), .gnt_onehot(o1));

  prio_arbiter_rr #(.N(5), .IDXW(3), .MODE(1)) u_rr5 (
    .clk(clk), .reset(reset), .en(en), .req(req5), .ready(ready),
    .gnt_valid(v2), .gnt_idx(i2), .gnt_onehot(o2));

  logic       dutValid [3];
  logic [2:0] dutIdx   [3];
  logic [4:0] dutOh    [3];

  assign dutValid[0] = v0;
  assign dutValid[1] = v1;
  assign dutValid[2] = v2;
  assign dutIdx[0]   = {1'b0, i0};
  assign dutIdx[1]   = {1'b0, i1};
  assign dutIdx[2]   = i2;
  assign dutOh[0]    = {1'b0, o0};
  assign dutOh[1]    = {1'b0, o1};
  assign dutOh[2]    = o2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: consume first (pointer takes the consumed index), then pick by explicit scan order.
  function automatic mstate_t modelNext(input int j, input mstate_t s);
    mstate_t    r;
    int         n;
    int         mode;
    int         c;
    bit         found;
    logic [4:0] rq;
    n    = (j == 2) ? 5 : 4;
    mode = (j == 0) ? 0 : 1;
    rq   = (j == 2) ? req5 : {1'b0, req5[3:0]};
    r    = s;
    if (reset) return '0;
    if (s.v && ready) r.ptr = s.idx;
    if (en && (!s.v || ready)) begin
      if (rq != 5'd0) begin
        found = 1'b0;
        for (int k = 1; k <= n; k++) begin
          if (mode == 0) c = n - k;
          else           c = (int'(r.ptr) - k + n) % n;
          if (!found && rq[c]) begin
            r.idx = 3'(c);
            found = 1'b1;
          end
        end
        r.v = 1'b1;
      end else begin
        r.v = 1'b0;
      end
    end else if (s.v && ready) begin
      r.v = 1'b0;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    for (int j = 0; j < 3; j++) mS[j] <= modelNext(j, mS[j]);
  end

  always @(negedge clk) begin
    if (checkEn) begin
      for (int j = 0; j < 3; j++) begin
        logic [4:0] expOh;
        expOh = mS[j].v ? (5'd1 << mS[j].idx) : 5'd0;
        vectors++;
        if (dutValid[j] !== mS[j].v || dutIdx[j] !== mS[j].idx || dutOh[j] !== expOh) begin
          miscompares++;
          $display("[TB] FAIL model inst%0d t=%0t: got valid=%0b idx=%0d onehot=%b, expected valid=%0b idx=%0d onehot=%b",
                   j, $time, dutValid[j], dutIdx[j], dutOh[j], mS[j].v, mS[j].idx, expOh);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [4:0] rq, input logic e, input logic rdy);
    reset = 1'b0;
    req5  = rq;
    en    = e;
    ready = rdy;
    @(negedge clk);
  endtask

  task automatic doReset(input int cycles, input logic [4:0] rq, input logic rdy);
    reset = 1'b1;
    req5  = rq;
    en    = 1'b1;
    ready = rdy;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int j, input logic ev,
                             input logic [2:0] eidx, input logic [4:0] eoh);
    vectors++;
    if (dutValid[j] !== ev || dutIdx[j] !== eidx || dutOh[j] !== eoh) begin
      miscompares++;
      $display("[TB] FAIL %s inst%0d: got valid=%0b idx=%0d onehot=%b, expected valid=%0b idx=%0d onehot=%b",
               name, j, dutValid[j], dutIdx[j], dutOh[j], ev, eidx, eoh);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    checkEn     = 1'b0;
    reset       = 1'b1;
    en          = 1'b1;
    ready       = 1'b1;
    req5        = 5'b01111;

    doReset(2, 5'b01111, 1'b1);
    checkEn = 1'b1;
    for (int j = 0; j < 3; j++) checkOutput("reset", j, 1'b0, 3'd0, 5'd0);

    // Fixed priority sequence
    applyStimulus(5'b01000, 1'b1, 1'b1); checkOutput("fixed_1000", 0, 1'b1, 3'd3, 5'b01000);
    applyStimulus(5'b00111, 1'b1, 1'b1); checkOutput("fixed_0111", 0, 1'b1, 3'd2, 5'b00100);
    applyStimulus(5'b00011, 1'b1, 1'b1); checkOutput("fixed_0011", 0, 1'b1, 3'd1, 5'b00010);
    applyStimulus(5'b00001, 1'b1, 1'b1); checkOutput("fixed_0001", 0, 1'b1, 3'd0, 5'b00001);
    applyStimulus(5'b00000, 1'b1, 1'b1); checkOutput("fixed_none", 0, 1'b0, 3'd0, 5'b00000);

    // Stall holds the grant while req changes
    applyStimulus(5'b00100, 1'b1, 1'b1); checkOutput("stall_load", 0, 1'b1, 3'd2, 5'b00100);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(5'b01000, 1'b1, 1'b0);
      checkOutput("stall_hold", 0, 1'b1, 3'd2, 5'b00100);
    end
    applyStimulus(5'b01000, 1'b1, 1'b1); checkOutput("stall_release", 0, 1'b1, 3'd3, 5'b01000);

    // Round-robin, N=4
    doReset(1, 5'b00000, 1'b1);
    begin
      logic [2:0] seq1111 [4];
      logic [2:0] seq0101 [4];
      seq1111 = '{3'd3, 3'd2, 3'd1, 3'd0};
      seq0101 = '{3'd2, 3'd0, 3'd2, 3'd0};
      for (int k = 0; k < 4; k++) begin
        applyStimulus(5'b01111, 1'b1, 1'b1);
        checkOutput("rr4_1111", 1, 1'b1, seq1111[k], 5'd1 << seq1111[k]);
      end
      for (int k = 0; k < 4; k++) begin
        applyStimulus(5'b00101, 1'b1, 1'b1);
        checkOutput("rr4_0101", 1, 1'b1, seq0101[k], 5'd1 << seq0101[k]);
      end
    end

    // Round-robin, N=5 wrap-around
    doReset(1, 5'b00000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(5'b10001, 1'b1, 1'b1);
      if (k % 2 == 0) checkOutput("rr5_alt", 2, 1'b1, 3'd4, 5'b10000);
      else            checkOutput("rr5_alt", 2, 1'b1, 3'd0, 5'b00001);
    end

    // en=0 while a grant is consumed
    applyStimulus(5'b00100, 1'b1, 1'b1); checkOutput("en_load", 0, 1'b1, 3'd2, 5'b00100);
    applyStimulus(5'b01000, 1'b0, 1'b1); checkOutput("en_drop", 0, 1'b0, 3'd2, 5'b00000);
    applyStimulus(5'b01000, 1'b0, 1'b1); checkOutput("en_idle", 0, 1'b0, 3'd2, 5'b00000);

    // Reset while a grant is held discards it and clears the pointer
    doReset(1, 5'b00000, 1'b1);
    applyStimulus(5'b01111, 1'b1, 1'b1); checkOutput("mid_g1", 1, 1'b1, 3'd3, 5'b01000);
    applyStimulus(5'b01111, 1'b1, 1'b1); checkOutput("mid_g2", 1, 1'b1, 3'd2, 5'b00100);
    applyStimulus(5'b01111, 1'b1, 1'b0); checkOutput("mid_hold", 1, 1'b1, 3'd2, 5'b00100);
    doReset(1, 5'b01111, 1'b0);
    checkOutput("mid_reset", 1, 1'b0, 3'd0, 5'b00000);
    applyStimulus(5'b01010, 1'b1, 1'b1); checkOutput("mid_after", 1, 1'b1, 3'd3, 5'b01000);

    // Random traffic checked every cycle by the model
    for (int k = 0; k < 3000; k++) begin
      logic [4:0] rq;
      rq = 5'($urandom);
      if ($urandom_range(0, 2) == 0) rq = rq & 5'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      req5  = rq;
      en    = ($urandom_range(0, 9) != 0);
      ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
    end

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
